result_requantizer: RTL and testbench
=====================================

// Module: result_requantizer
// PURPOSE
//  Downstream consumer of the 4x4 systolic array's output stream (64-bit beats, two int32 results each).
//  Collects the 16 int32 results of one matrix, requantizes each to int8, and packs them
//  into two 64-bit output words. Per element: round, arithmetic shift, optional ReLU, saturate.
//  Sits between the array's output datapath and the next layer/host buffer. Ready/valid on both sides.
// PARAMETERS
//  ACC_W     32  width of each incoming accumulator element (signed); IN_W/ACC_W elems per beat
//  IN_W      64  input/output beat width
//  ELEMS     16  elements per matrix (8 input beats, 2 output words)
//  ROUND_EN  1   1: add 2^(shift-1) before shifting (round-half-up); 0: truncate
// PORTS
//  clk           in   1   clock, rising edge
//  reset         in   1   reset, asynchronous, active-high
//  in_valid      in   1   upstream beat valid (array output dest_valid)
//  in_data       in   64  [63:32] = earlier element (row-major), [31:0] = next element
//  in_ready      out  1   beat accepted when in_valid && in_ready
//  cfg_shift     in   5   right-shift amount 0..31; latched on first beat of each matrix
//  cfg_relu      in   1   1: clamp negatives to 0; latched with cfg_shift
//  out_valid     out  1   packed word valid
//  out_data      out  64  8 int8 results, [63:56] = earliest element of the word
//  out_ready     in   1   downstream accepts when out_valid && out_ready
//  out_last      out  1   high with out_valid on the 2nd (final) word of a matrix
//  matrix_done   out  1   one-cycle pulse on the handshake of the final word
// BEHAVIOUR
//  Reset: state=IDLE, beat_cnt=0, out_valid=0, out_data=0, out_last=0, matrix_done=0,
//    in_ready=0 during reset; pack register and latched cfg cleared.
//  FSM: IDLE -> COLLECT on first accepted beat (latch cfg_shift/cfg_relu, beat_cnt=1).
//    COLLECT -> DRAIN when 8th beat accepted. DRAIN -> IDLE on final-word handshake.
//  in_ready: IDLE/COLLECT: 1, except 0 on a word-completing beat (beat_cnt%4==3) while
//    out_valid && !out_ready. DRAIN: 0.
//  Element math (per int32 x, latched s, r): t = x + (ROUND_EN && s!=0 ? 2^(s-1) : 0), computed
//    at ACC_W+1 bits (no wrap); q = t >>> s; if r && q<0 then q=0; saturate to [-128,127].
//  Packing: each beat yields 2 bytes into 6-byte pack reg; the 4th beat of a word combines
//    with pack reg and loads out_data; out_valid=1 the next cycle (latency 1 from acceptance).
//  out_data/out_valid/out_last hold stable until out_ready; out_valid drops after handshake
//    unless a new word loads the same cycle (back-to-back allowed within a matrix).
//  Word 0 may still be pending when word 1 completes: that beat is stalled via in_ready=0;
//    in IDLE/COLLECT a pending word can drain while the next word's first 3 beats are taken.
//  Next-matrix beats accepted only after IDLE is re-entered (cycle after matrix_done).
//  cfg changes mid-matrix have no effect until the next matrix's first beat.
//  Reset mid-matrix: partial data discarded, no matrix_done, resumes in IDLE.
//  in_valid while in DRAIN: ignored (not accepted), no error flag.
// TESTING
//  1) shift=0, relu=0, beats {5,-3},{1,2},... -> word0 bytes 05 FD 01 02 ...; out_valid 1 cycle after beat 4.
//  2) shift=4, ROUND_EN=1: x=24 -> 0x02, x=23 -> 0x01, x=-24 -> 0xFF (t=-16, >>>4 = -1).
//  3) Saturation: x=1000 -> 0x7F, x=-1000 -> 0x80, x=0x7FFFFFFF shift=31 -> 0x01 (no overflow).
//  4) relu=1: x=-5 -> 0x00, x=7 -> 0x07; relu toggled mid-matrix -> no effect on current matrix.
//  5) Backpressure: out_ready=0 through 8 beats -> in_ready=0 on beat 8; data/last stable;
//     release -> 2 words, out_last on 2nd, matrix_done pulses once, state returns to IDLE.
//  6) Reset asserted after beat 5 -> outputs zero; fresh 8-beat matrix -> correct 2 words.

Source files
------------

// File: rtl/result_requantizer.sv
// Requantizes a 16-element int32 matrix result stream to int8 and packs it into two
// 64-bit words. Per element: optional round-half-up, arithmetic shift, optional ReLU, saturate.
module result_requantizer #(
    parameter int ACC_W    = 32,
    parameter int IN_W     = 64,
    parameter int ELEMS    = 16,
    parameter bit ROUND_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    input  logic [4:0]      cfg_shift,
    input  logic            cfg_relu,
    output logic            out_valid,
    output logic [IN_W-1:0] out_data,
    input  logic            out_ready,
    output logic            out_last,
    output logic            matrix_done
);

    localparam int EPB    = IN_W / ACC_W;
    localparam int BEATS  = ELEMS / EPB;
    localparam int CNT_W  = $clog2(BEATS);
    localparam int PACK_W = IN_W - 16;
    localparam logic [CNT_W-1:0]      LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic signed [ACC_W:0] SAT_HI    = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] SAT_LO    = ~SAT_HI;

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [PACK_W-1:0]   pack_q, pack_d;
    logic [4:0]          shift_q, shift_d;
    logic                relu_q, relu_d;
    logic [IN_W-1:0]     out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;

    logic [4:0] eff_shift;
    logic       eff_relu;
    logic [7:0] byte_hi, byte_lo;
    logic       word_beat, in_fire, out_fire;

    // The sum is carried at ACC_W+1 bits so the rounding bias can never wrap.
    function automatic logic [7:0] requant(input logic signed [ACC_W-1:0] x,
                                           input logic [4:0] s, input logic r);
        logic signed [ACC_W:0] t;
        logic signed [ACC_W:0] q;
        t = {x[ACC_W-1], x};
        if (ROUND_EN && s != 5'd0)
            t = t + ((ACC_W+1)'(1) << (s - 5'd1));
        q = t >>> s;
        if (r && q[ACC_W])
            q = '0;
        if (q > SAT_HI)
            return 8'h7F;
        if (q < SAT_LO)
            return 8'h80;
        return q[7:0];
    endfunction

    always_comb begin
        // The first beat of a matrix uses the live cfg, since it is only latched on that beat.
        eff_shift = (state_q == IDLE) ? cfg_shift : shift_q;
        eff_relu  = (state_q == IDLE) ? cfg_relu  : relu_q;
        byte_hi   = requant(in_data[IN_W-1 -: ACC_W], eff_shift, eff_relu);
        byte_lo   = requant(in_data[ACC_W-1:0], eff_shift, eff_relu);

        word_beat   = (beat_cnt_q[1:0] == 2'd3);
        out_fire    = out_valid_q && out_ready;
        in_ready    = !reset && (state_q != DRAIN) &&
                      !(word_beat && out_valid_q && !out_ready);
        in_fire     = in_valid && in_ready;
        matrix_done = out_fire && out_last_q;

        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        pack_d      = pack_q;
        shift_d     = shift_q;
        relu_d      = relu_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;

        if (out_fire) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        if (in_fire) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (state_q == IDLE) begin
                shift_d = cfg_shift;
                relu_d  = cfg_relu;
                state_d = COLLECT;
            end
            case (beat_cnt_q[1:0])
                2'd0:    pack_d[PACK_W-1 -: 16]  = {byte_hi, byte_lo};
                2'd1:    pack_d[PACK_W-17 -: 16] = {byte_hi, byte_lo};
                2'd2:    pack_d[15:0]            = {byte_hi, byte_lo};
                default: begin
                    out_data_d  = {pack_q, byte_hi, byte_lo};
                    out_valid_d = 1'b1;
                    out_last_d  = (beat_cnt_q == LAST_BEAT);
                end
            endcase
            if (beat_cnt_q == LAST_BEAT)
                state_d = DRAIN;
        end

        if (state_q == DRAIN && matrix_done)
            state_d = IDLE;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            beat_cnt_q  <= '0;
            pack_q      <= '0;
            shift_q     <= '0;
            relu_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            pack_q      <= pack_d;
            shift_q     <= shift_d;
            relu_q      <= relu_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_result_requantizer.sv
// Directed bench for result_requantizer: arithmetic corner cases, cfg latching,
// backpressure on both sides and mid-matrix reset, with hand-computed expected words.
module tb_result_requantizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [63:0] in_data = '0;
    logic        in_ready;
    logic [4:0]  cfg_shift = '0;
    logic        cfg_relu = 1'b0;
    logic        out_valid;
    logic [63:0] out_data;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic        matrix_done;

    int errors = 0;
    int checks = 0;

    logic [63:0] q_data[$];
    logic        q_last[$];
    int          done_cnt = 0;

    int m1[16] = '{5, -3, 1, 2, -1, 127, 128, -129, 0, 100, -100, -128, 7, -7, 64, -64};
    localparam logic [63:0] M1_W0 = 64'h05FD_0102_FF7F_7F80;
    localparam logic [63:0] M1_W1 = 64'h0064_9C80_07F9_40C0;

    always #5 clk = ~clk;

    result_requantizer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .cfg_shift   (cfg_shift),
        .cfg_relu    (cfg_relu),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .matrix_done (matrix_done)
    );

    // Records every output handshake and matrix_done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            q_data.push_back(out_data);
            q_last.push_back(out_last);
        end
        if (!reset && matrix_done)
            done_cnt++;
    end

    task automatic send_beat(input int a, input int b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = {a, b};
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL beat_accept: in_ready=%b want 1 after %0d cycles", in_ready, n);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_matrix(input int e[16]);
        for (int i = 0; i < 8; i++)
            send_beat(e[2*i], e[2*i+1]);
    endtask

    task automatic wait_words(input int target);
        int n;
        n = 0;
        while (q_data.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q_data.size() < target) begin
            errors++;
            $display("FAIL word_wait: got %0d words want %0d", q_data.size(), target);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 64'h0 ||
            out_last !== 1'b0 || matrix_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b vld=%b data=%h last=%b done=%b want all 0",
                     in_ready, out_valid, out_data, out_last, matrix_done);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_passthrough();
        int b, d0;
        b  = q_data.size();
        d0 = done_cnt;
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(m1[2*i], m1[2*i+1]);
            if (i == 2) begin
                checks++;
                if (out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL t1_early_valid: out_valid=%b want 0", out_valid);
                end
            end
            if (i == 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== M1_W0) begin
                    errors++;
                    $display("FAIL t1_latency: vld=%b data=%h want 1/%h", out_valid, out_data, M1_W0);
                end
            end
        end
        wait_words(b + 2);
        checks++;
        if (q_data[b] !== M1_W0 || q_last[b] !== 1'b0) begin
            errors++;
            $display("FAIL t1_word0: got %h last=%b want %h last=0", q_data[b], q_last[b], M1_W0);
        end
        checks++;
        if (q_data[b+1] !== M1_W1 || q_last[b+1] !== 1'b1) begin
            errors++;
            $display("FAIL t1_word1: got %h last=%b want %h last=1", q_data[b+1], q_last[b+1], M1_W1);
        end
        checks++;
        if (done_cnt - d0 !== 1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL t1_done: pulses=%0d in_ready=%b want 1/1", done_cnt - d0, in_ready);
        end
    endtask

    task automatic run_matrix(input string name, input int e[16], input logic [4:0] sh,
                              input logic [63:0] w0, input logic [63:0] w1);
        int b;
        b = q_data.size();
        cfg_shift = sh;
        cfg_relu  = 1'b0;
        out_ready = 1'b1;
        send_matrix(e);
        wait_words(b + 2);
        checks++;
        if (q_data[b] !== w0) begin
            errors++;
            $display("FAIL %s_word0: got %h want %h", name, q_data[b], w0);
        end
        checks++;
        if (q_data[b+1] !== w1) begin
            errors++;
            $display("FAIL %s_word1: got %h want %h", name, q_data[b+1], w1);
        end
    endtask

    task automatic test_rounding();
        int m[16] = '{24, 23, -24, 8, 7, -8, -9, 2047,
                      2048, -2056, -2057, 0, 40, -40, 100, -100};
        run_matrix("t2_round", m, 5'd4, 64'h0201_FF01_0000_FF7F, 64'h7F80_8000_03FE_06FA);
    endtask

    task automatic test_saturation();
        int ma[16] = '{int'(32'h7FFFFFFF), int'(32'h80000000), int'(32'h40000000),
                       int'(32'h3FFFFFFF), -1, int'(32'hC0000000), int'(32'hBFFFFFFF), 0,
                       int'(32'h7FFFFFFF), int'(32'h7FFFFFFF), int'(32'h7FFFFFFF),
                       int'(32'h7FFFFFFF), int'(32'h7FFFFFFF), int'(32'h7FFFFFFF),
                       int'(32'h7FFFFFFF), int'(32'h7FFFFFFF)};
        int mb[16] = '{1000, -1000, int'(32'h7FFFFFFF), int'(32'h80000000), 127, -128, 128, -129,
                       0, 1, -1, 2, -2, 255, -255, 300};
        run_matrix("t3_shift31", ma, 5'd31, 64'h01FF_0100_0000_FF00, 64'h0101_0101_0101_0101);
        run_matrix("t3_sat", mb, 5'd0, 64'h7F80_7F80_7F80_7F80, 64'h0001_FF02_FE7F_807F);
    endtask

    task automatic test_relu();
        int m[16] = '{-5, 7, -1, 0, 127, -128, 200, -200,
                      3, -3, 1000, -1000, 64, -64, 1, -1};
        int b;
        b = q_data.size();
        cfg_shift = 5'd0;
        cfg_relu  = 1'b1;
        out_ready = 1'b1;
        send_beat(m[0], m[1]);
        cfg_relu  = 1'b0;
        cfg_shift = 5'd5;
        for (int i = 1; i < 8; i++)
            send_beat(m[2*i], m[2*i+1]);
        wait_words(b + 2);
        checks++;
        if (q_data[b] !== 64'h0007_0000_7F00_7F00) begin
            errors++;
            $display("FAIL t4_relu_word0: got %h want %h", q_data[b], 64'h0007_0000_7F00_7F00);
        end
        checks++;
        if (q_data[b+1] !== 64'h0300_7F00_4000_0100) begin
            errors++;
            $display("FAIL t4_relu_word1: got %h want %h", q_data[b+1], 64'h0300_7F00_4000_0100);
        end
        cfg_shift = 5'd0;
    endtask

    task automatic test_back_to_back_backpressure();
        int  b, d0;
        logic bad;
        b  = q_data.size();
        d0 = done_cnt;
        cfg_shift = 5'd0;
        cfg_relu  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++)
            send_beat(m1[2*i], m1[2*i+1]);
        checks++;
        if (out_valid !== 1'b1 || out_data !== M1_W0 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL t5_word0_hold: vld=%b data=%h last=%b want 1/%h/0",
                     out_valid, out_data, out_last, M1_W0);
        end
        in_valid = 1'b1;
        in_data  = {m1[14], m1[15]};
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== M1_W0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL t5_stall: in_ready=%b data=%h want 0/%h stable", in_ready, out_data, M1_W0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_data   = {32'd99, 32'd99};
        checks++;
        if (out_valid !== 1'b1 || out_data !== M1_W1 || out_last !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL t5_word1_load: vld=%b data=%h last=%b rdy=%b want 1/%h/1/0",
                     out_valid, out_data, out_last, in_ready, M1_W1);
        end
        bad = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (in_ready !== 1'b0 || matrix_done !== 1'b0 || out_data !== M1_W1 || out_last !== 1'b1)
                bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL t5_drain_hold: rdy=%b done=%b data=%h last=%b want 0/0/%h/1",
                     in_ready, matrix_done, out_data, out_last, M1_W1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (matrix_done !== 1'b1) begin
            errors++;
            $display("FAIL t5_done_pulse: matrix_done=%b want 1", matrix_done);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || matrix_done !== 1'b0) begin
            errors++;
            $display("FAIL t5_idle: rdy=%b vld=%b done=%b want 1/0/0", in_ready, out_valid, matrix_done);
        end
        checks++;
        if (q_data.size() != b + 2 || q_data[b] !== M1_W0 || q_data[b+1] !== M1_W1 ||
            q_last[b] !== 1'b0 || q_last[b+1] !== 1'b1 || done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL t5_stream: words=%0d w0=%h w1=%h pulses=%0d want %0d/%h/%h/1",
                     q_data.size() - b, q_data[b], q_data[b+1], done_cnt - d0, 2, M1_W0, M1_W1);
        end
    endtask

    task automatic test_reset_mid_matrix();
        int d0;
        d0 = done_cnt;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++)
            send_beat(m1[2*i] + 1, m1[2*i+1] + 1);
        reset = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || out_last !== 1'b0 ||
            in_ready !== 1'b0 || matrix_done !== 1'b0) begin
            errors++;
            $display("FAIL t6_reset_outputs: vld=%b data=%h last=%b rdy=%b done=%b want all 0",
                     out_valid, out_data, out_last, in_ready, matrix_done);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        checks++;
        if (done_cnt != d0) begin
            errors++;
            $display("FAIL t6_no_done: pulses=%0d want 0", done_cnt - d0);
        end
        run_matrix("t6_fresh", m1, 5'd0, M1_W0, M1_W1);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_rounding();
        test_saturation();
        test_relu();
        test_back_to_back_backpressure();
        test_reset_mid_matrix();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

endmodule
